// File: rtl/crc_pkg.sv
// Shared types and helpers for the bit-serial CRC engine and the legacy LFSR path.
package crc_pkg;

  localparam int CRC_MAX_W = 64;
  localparam int CRC_WB    = $clog2(CRC_MAX_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } crc_state_e;

  typedef struct packed {
    logic [CRC_WB-1:0]    width;
    logic [CRC_MAX_W-1:0] poly;
    logic [CRC_MAX_W-1:0] init;
    logic [CRC_MAX_W-1:0] xorout;
    logic                 refin;
    logic                 refout;
  } crc_cfg_t;

  // Bit-reverse the low (w_m1+1) bits of value; bits above are cleared.
  function automatic logic [CRC_MAX_W-1:0] rev_w(input logic [CRC_MAX_W-1:0] value,
                                                 input logic [CRC_WB-1:0]    w_m1);
    logic [CRC_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < CRC_MAX_W; i++) begin
      if (i <= int'(w_m1)) begin
        r[i] = value[CRC_WB'(int'(w_m1) - i)];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_bit_step.sv
// Combinational single-bit CRC register update for a variable-width register.
module crc_bit_step #(
  parameter  int W  = 64,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  crc_i,
  input  logic [W-1:0]  poly_i,
  input  logic [W-1:0]  mask_i,
  input  logic [IW-1:0] top_idx_i,
  input  logic          din_i,
  output logic [W-1:0]  crc_o
);

  logic fb_s;

  // Feedback from the current top bit of the active width
  always_comb begin
    fb_s  = crc_i[top_idx_i] ^ din_i;
    crc_o = ((crc_i << 1'b1) ^ (fb_s ? poly_i : {W{1'b0}})) & mask_i;
  end

endmodule

// File: rtl/crc_stream_engine.sv
// Parametrised serial CRC engine: config snapshot, byte stream in, one bit per
// clock, optional reflection and final XOR, valid/ready result handshake.
module crc_stream_engine
  import crc_pkg::*;
#(
  parameter  int MAX_WIDTH = 64,
  parameter  int DIN_BITS  = 8,
  localparam int WB        = $clog2(MAX_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 abort,
  input  logic                 cfg_load,
  input  logic [WB-1:0]        cfg_width,
  input  logic [MAX_WIDTH-1:0] cfg_poly,
  input  logic [MAX_WIDTH-1:0] cfg_init,
  input  logic [MAX_WIDTH-1:0] cfg_xorout,
  input  logic                 cfg_refin,
  input  logic                 cfg_refout,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIN_BITS-1:0]  in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAX_WIDTH-1:0] out_crc,
  output logic                 busy
);

  localparam int CW = $clog2(DIN_BITS + 1);

  crc_state_e           state_q, state_d;
  crc_cfg_t             cfg_q, cfg_d;
  logic [MAX_WIDTH-1:0] crc_q, crc_d;
  logic [CW-1:0]        bitcnt_q, bitcnt_d;
  logic [DIN_BITS-1:0]  data_q, data_d;
  logic                 last_q, last_d;
  logic [MAX_WIDTH-1:0] out_crc_q, out_crc_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [MAX_WIDTH-1:0] mask_s, mask_in_s, step_s, refl_s, fin_s;
  logic [CRC_MAX_W-1:0] rev_s;
  logic                 bit_s;

  // Masks for the snapshotted width and for the width being loaded; since
  // MAX_WIDTH is a power of two, ~(w-1) equals MAX_WIDTH - w.
  assign mask_s    = {MAX_WIDTH{1'b1}} >> (~WB'(cfg_q.width));
  assign mask_in_s = {MAX_WIDTH{1'b1}} >> (~cfg_width);

  // The beat register shifts toward the consumed end, so the next bit is always at a fixed position.
  assign bit_s = cfg_q.refin ? data_q[0] : data_q[DIN_BITS-1];

  crc_bit_step #(.W(MAX_WIDTH)) u_step (
    .crc_i     (crc_q),
    .poly_i    (cfg_q.poly[MAX_WIDTH-1:0]),
    .mask_i    (mask_s),
    .top_idx_i (WB'(cfg_q.width)),
    .din_i     (bit_s),
    .crc_o     (step_s)
  );

  assign rev_s  = rev_w(CRC_MAX_W'(step_s), cfg_q.width);
  assign refl_s = cfg_q.refout ? rev_s[MAX_WIDTH-1:0] : step_s;
  assign fin_s  = (refl_s ^ cfg_q.xorout[MAX_WIDTH-1:0]) & mask_s;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    crc_d     = crc_q;
    bitcnt_d  = bitcnt_q;
    data_d    = data_q;
    last_d    = last_q;
    out_crc_d = out_crc_q;
    if (abort) begin
      state_d   = ST_IDLE;
      crc_d     = '0;
      out_crc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_load) begin
            cfg_d.width  = CRC_WB'(cfg_width);
            cfg_d.poly   = CRC_MAX_W'(cfg_poly);
            cfg_d.init   = CRC_MAX_W'(cfg_init);
            cfg_d.xorout = CRC_MAX_W'(cfg_xorout);
            cfg_d.refin  = cfg_refin;
            cfg_d.refout = cfg_refout;
            crc_d        = cfg_init & mask_in_s;
            state_d      = ST_ACCEPT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            data_d   = in_data;
            last_d   = in_last;
            bitcnt_d = '0;
            state_d  = ST_SHIFT;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
        ST_SHIFT: begin
          crc_d    = step_s;
          data_d   = cfg_q.refin ? (data_q >> 1'b1) : (data_q << 1'b1);
          bitcnt_d = bitcnt_q + CW'(1);
          if (bitcnt_q == CW'(DIN_BITS - 1)) begin
            if (last_q) begin
              out_crc_d = fin_s;
              state_d   = ST_DONE;
            end else begin
              state_d = ST_ACCEPT;
            end
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    in_ready_d  = (state_d == ST_ACCEPT);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, config snapshot, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      crc_q       <= '0;
      bitcnt_q    <= '0;
      data_q      <= '0;
      last_q      <= 1'b0;
      out_crc_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      crc_q       <= crc_d;
      bitcnt_q    <= bitcnt_d;
      data_q      <= data_d;
      last_q      <= last_d;
      out_crc_q   <= out_crc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_crc_stream_engine.sv
// Directed self-checking bench for crc_stream_engine using standard CRC check values.
module tb_crc_stream_engine;

  localparam int MW = 64;
  localparam int DB = 8;
  localparam int WB = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          abort;
  logic          cfg_load;
  logic [WB-1:0] cfg_width;
  logic [MW-1:0] cfg_poly, cfg_init, cfg_xorout;
  logic          cfg_refin, cfg_refout;
  logic          in_valid, in_ready;
  logic [DB-1:0] in_data;
  logic          in_last;
  logic          out_valid, out_ready;
  logic [MW-1:0] out_crc;
  logic          busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  crc_stream_engine #(.MAX_WIDTH(MW), .DIN_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .abort      (abort),
    .cfg_load   (cfg_load),
    .cfg_width  (cfg_width),
    .cfg_poly   (cfg_poly),
    .cfg_init   (cfg_init),
    .cfg_xorout (cfg_xorout),
    .cfg_refin  (cfg_refin),
    .cfg_refout (cfg_refout),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_crc    (out_crc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic load_cfg(input logic [WB-1:0] wm1, input logic [MW-1:0] poly,
                          input logic [MW-1:0] init, input logic [MW-1:0] xorout,
                          input logic refin, input logic refout);
    @(posedge clk); #1;
    cfg_width = wm1; cfg_poly = poly; cfg_init = init; cfg_xorout = xorout;
    cfg_refin = refin; cfg_refout = refout; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    // Scramble the live config so only the snapshot can produce a correct result.
    cfg_width = ~wm1; cfg_poly = ~poly; cfg_init = ~init; cfg_xorout = ~xorout;
    cfg_refin = ~refin; cfg_refout = ~refout;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_accept: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_beat(msg[i], (i == n - 1));
  endtask

  task automatic wait_valid(output logic ok);
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    ok = (out_valid === 1'b1);
  endtask

  task automatic get_result(output logic [MW-1:0] crc, output logic ok);
    wait_valid(ok);
    crc = out_crc;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #6;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_crc !== 64'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%0b vld=%0b busy=%0b crc=%h required all 0",
               in_ready, out_valid, busy, out_crc);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_std(input string name, input logic [WB-1:0] wm1, input logic [MW-1:0] poly,
                          input logic [MW-1:0] init, input logic [MW-1:0] xorout,
                          input logic refl, input logic [MW-1:0] exp_crc);
    logic [MW-1:0] crc;
    logic ok;
    load_cfg(wm1, poly, init, xorout, refl, refl);
    send_msg(9);
    get_result(crc, ok);
    checks++;
    if (!ok || crc !== exp_crc) begin
      errors++;
      $display("FAIL %s: valid=%0b crc=%h required %h", name, ok, crc, exp_crc);
    end
  endtask

  task automatic test_latency();
    int n;
    load_cfg(6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h31; in_last = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    n = 1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL shift_flags: in_ready=%0b busy=%0b required 0/1", in_ready, busy);
    end
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || n != DB + 1) begin
      errors++;
      $display("FAIL latency: cycles=%0d valid=%0b required %0d", n, out_valid, DB + 1);
    end
    checks++;
    if (out_crc !== 64'h97) begin
      errors++;
      $display("FAIL single_beat_crc: crc=%h required 97", out_crc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release: valid=%0b busy=%0b required 0/0", out_valid, busy);
    end
  endtask

  task automatic test_hold();
    logic ok;
    int bad = 0;
    load_cfg(6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    send_msg(9);
    wait_valid(ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_crc !== 64'hF4) bad++;
    end
    checks++;
    if (!ok || bad != 0) begin
      errors++;
      $display("FAIL hold: valid=%0b unstable_cycles=%0d crc=%h required 1/0/f4", ok, bad, out_crc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_gaps();
    logic [MW-1:0] crc;
    logic ok;
    load_cfg(6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      if (i == 4) begin
        // cfg_load outside IDLE must be ignored
        cfg_load = 1'b1; cfg_width = 6'd15; cfg_poly = 64'h1021; cfg_init = 64'hFFFF;
        @(posedge clk); #1;
        cfg_load = 1'b0;
      end
      send_beat(msg[i], (i == 8));
    end
    get_result(crc, ok);
    checks++;
    if (!ok || crc !== 64'hF4) begin
      errors++;
      $display("FAIL gaps_crc8: valid=%0b crc=%h required f4", ok, crc);
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    load_cfg(6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    send_beat(msg[0], 1'b0);
    send_beat(msg[1], 1'b0);
    send_beat(msg[2], 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%0b rdy=%0b vld=%0b required 0", busy, in_ready, out_valid);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_result: out_valid cycles=%0d required 0", seen);
    end
  endtask

  task automatic test_width1();
    logic [MW-1:0] crc;
    logic ok;
    load_cfg(6'd0, {MW{1'b1}}, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1);
    send_beat(8'h31, 1'b1);
    get_result(crc, ok);
    checks++;
    if (!ok || crc !== 64'h1) begin
      errors++;
      $display("FAIL width1_parity: valid=%0b crc=%h required 1", ok, crc);
    end
  endtask

  task automatic test_reset_in_done();
    logic ok;
    load_cfg(6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 1'b0);
    send_beat(8'h31, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || out_crc !== 64'h97) begin
      errors++;
      $display("FAIL pre_reset_done: valid=%0b crc=%h required 1/97", ok, out_crc);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000 || out_crc !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: rdy=%0b vld=%0b busy=%0b crc=%h required all 0",
               in_ready, out_valid, busy, out_crc);
    end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; abort = 1'b0; cfg_load = 1'b0; cfg_width = '0;
    cfg_poly = '0; cfg_init = '0; cfg_xorout = '0; cfg_refin = 1'b0; cfg_refout = 1'b0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    test_reset();
    test_std("crc8", 6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 64'hF4);
    test_latency();
    test_hold();
    test_gaps();
    test_abort();
    test_std("crc16_ccitt", 6'd15, 64'h1021, 64'hFFFF, 64'h0, 1'b0, 64'h29B1);
    test_std("crc32", 6'd31, 64'hDEAD_0000_04C1_1DB7, {MW{1'b1}}, {MW{1'b1}}, 1'b1, 64'hCBF4_3926);
    test_std("crc64_ecma", 6'd63, 64'h42F0_E1EB_A9EA_3693, 64'h0, 64'h0, 1'b0, 64'h6C40_DF5F_0B49_7347);
    test_width1();
    test_reset_in_done();
    test_std("crc8_after_reset", 6'd7, 64'h07, 64'h0, 64'h0, 1'b0, 64'hF4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
